// File: rtl/parking_sensor_driver_pkg.sv
// ============================================================================
// parking_pkg: command/state types and phase pattern lookup for the
// parking-lot gate sensor driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  typedef enum logic [1:0] {
    CAR_IN  = 2'b00,
    CAR_OUT = 2'b01,
    PED_IN  = 2'b10,
    PED_OUT = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } drv_state_t;

  // Cars overlap both beams in the middle phase; pedestrians clear both.
  function automatic logic [1:0] phase_pattern(input cmd_t c, input drv_state_t s);
    logic exiting;
    logic car;
    exiting = c[0];
    car     = ~c[1];
    case (s)
      PH1:     phase_pattern = exiting ? 2'b01 : 2'b10;
      PH2:     phase_pattern = car ? 2'b11 : 2'b00;
      PH3:     phase_pattern = exiting ? 2'b10 : 2'b01;
      default: phase_pattern = 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_sensor_driver_phase_timer.sv
// ============================================================================
// phase_timer: loadable down-counter that stops at zero; zero flags expiry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/parking_sensor_driver.sv
// ============================================================================
// parking_sensor_driver: turns queued traffic commands into timed outer/inner
// beam-blocked waveforms. Optional counters enabled by PARK_DRV_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_sensor_driver
  import parking_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       outer,
  output logic       inner,
  output logic       busy,
  output logic       done
`ifdef PARK_DRV_COUNT_EN
  ,
  output logic [7:0] cars_sent,
  output logic [7:0] peds_sent
`endif
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  drv_state_t    state;
  drv_state_t    next_state;
  cmd_t          cmd_q;
  cmd_t          cmd_next;
  logic          timer_load;
  logic [TW-1:0] timer_load_value;
  logic          timer_zero;
  logic          seq_complete;

  phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_load_value),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_q <= CAR_IN;
    end else begin
      state <= next_state;
      cmd_q <= cmd_next;
    end
  end

  always_comb begin
    next_state       = state;
    cmd_next         = cmd_q;
    timer_load       = 1'b0;
    timer_load_value = HOLD_LOAD;
    seq_complete     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          next_state = PH1;
          cmd_next   = cmd_t'(cmd);
          timer_load = 1'b1;
        end
      end
      PH1: begin
        if (timer_zero) begin
          next_state = PH2;
          timer_load = 1'b1;
        end
      end
      PH2: begin
        if (timer_zero) begin
          next_state = PH3;
          timer_load = 1'b1;
        end
      end
      PH3: begin
        if (timer_zero) begin
          next_state       = GAP;
          timer_load       = 1'b1;
          timer_load_value = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          next_state   = IDLE;
          seq_complete = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      outer     <= 1'b0;
      inner     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      {outer, inner} <= phase_pattern(cmd_next, next_state);
      busy           <= (next_state != IDLE);
      cmd_ready      <= (next_state == IDLE);
      done           <= seq_complete;
    end
  end

`ifdef PARK_DRV_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cars_sent <= 8'd0;
      peds_sent <= 8'd0;
    end else if (seq_complete) begin
      if (cmd_q[1]) begin
        if (peds_sent != 8'hFF) peds_sent <= peds_sent + 8'd1;
      end else begin
        if (cars_sent != 8'hFF) cars_sent <= cars_sent + 8'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_parking_sensor_driver.sv
// ============================================================================
// tb_parking_sensor_driver: table-driven and directed checks of the driver
// with HOLD_CYCLES=2/GAP_CYCLES=1 and HOLD_CYCLES=1/GAP_CYCLES=1 instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_sensor_driver;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       outer;
  logic       inner;
  logic       busy;
  logic       done;
  logic       cmd_valid1;
  logic [1:0] cmd1;
  logic       cmd_ready1;
  logic       outer1;
  logic       inner1;
  logic       busy1;
  logic       done1;
`ifdef PARK_DRV_COUNT_EN
  logic [7:0] cars_sent;
  logic [7:0] peds_sent;
  logic [7:0] cars_sent1;
  logic [7:0] peds_sent1;
`endif

  int tests = 0;
  int fails = 0;

  parking_sensor_driver #(
    .HOLD_CYCLES(2),
    .GAP_CYCLES (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready),
    .outer    (outer),
    .inner    (inner),
    .busy     (busy),
    .done     (done)
`ifdef PARK_DRV_COUNT_EN
    ,
    .cars_sent(cars_sent),
    .peds_sent(peds_sent)
`endif
  );

  parking_sensor_driver #(
    .HOLD_CYCLES(1),
    .GAP_CYCLES (1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid1),
    .cmd      (cmd1),
    .cmd_ready(cmd_ready1),
    .outer    (outer1),
    .inner    (inner1),
    .busy     (busy1),
    .done     (done1)
`ifdef PARK_DRV_COUNT_EN
    ,
    .cars_sent(cars_sent1),
    .peds_sent(peds_sent1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic       valid;
    logic [1:0] cmd;
    logic [4:0] exp;  // {outer, inner, busy, cmd_ready, done}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] c, input logic [4:0] e);
    vec_t r;
    r.valid = v;
    r.cmd   = c;
    r.exp   = e;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(name, {15'd0, done}, 16'd1);
  endtask

  task automatic run_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    step();
    cmd_valid = 1'b0;
    wait_done("run_cmd_done");
  endtask

  logic [2:0] exp1[6];

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd        = 2'b00;
    cmd_valid1 = 1'b0;
    cmd1       = 2'b00;

    // CAR_IN
    add(1'b1, 2'b00, 5'b00010);
    add(1'b0, 2'b00, 5'b10100);
    add(1'b0, 2'b00, 5'b10100);
    add(1'b0, 2'b00, 5'b11100);
    add(1'b0, 2'b00, 5'b11100);
    add(1'b0, 2'b00, 5'b01100);
    add(1'b0, 2'b00, 5'b01100);
    add(1'b0, 2'b00, 5'b00100);
    add(1'b0, 2'b00, 5'b00011);
    // PED_OUT
    add(1'b1, 2'b11, 5'b00010);
    add(1'b0, 2'b11, 5'b01100);
    add(1'b0, 2'b11, 5'b01100);
    add(1'b0, 2'b11, 5'b00100);
    add(1'b0, 2'b11, 5'b00100);
    add(1'b0, 2'b11, 5'b10100);
    add(1'b0, 2'b11, 5'b10100);
    add(1'b0, 2'b11, 5'b00100);
    add(1'b0, 2'b11, 5'b00011);
    // CAR_OUT with cmd changing mid-sequence
    add(1'b1, 2'b01, 5'b00010);
    add(1'b0, 2'b10, 5'b01100);
    add(1'b0, 2'b10, 5'b01100);
    add(1'b0, 2'b10, 5'b11100);
    add(1'b0, 2'b10, 5'b11100);
    add(1'b0, 2'b10, 5'b10100);
    add(1'b0, 2'b10, 5'b10100);
    add(1'b0, 2'b10, 5'b00100);
    add(1'b0, 2'b10, 5'b00011);
    add(1'b0, 2'b00, 5'b00010);

    exp1[0] = 3'b000;
    exp1[1] = 3'b010;
    exp1[2] = 3'b110;
    exp1[3] = 3'b100;
    exp1[4] = 3'b000;
    exp1[5] = 3'b001;

    step();
    step();
    @(negedge clk);
    check("reset_state", {12'd0, outer, inner, busy, done}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_release", {11'd0, outer, inner, busy, cmd_ready, done}, 16'b00010);
    step();

    foreach (tbl[i]) begin
      cmd_valid = tbl[i].valid;
      cmd       = tbl[i].cmd;
      @(negedge clk);
      check($sformatf("vec%0d", i), {11'd0, outer, inner, busy, cmd_ready, done},
            {11'd0, tbl[i].exp});
      step();
    end
    cmd_valid = 1'b0;

    // Command held while busy: accepted only in the done cycle.
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    @(negedge clk);
    check("b2b_first_ready", {15'd0, cmd_ready}, 16'd1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    cmd_valid = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("b2b_hold_c%0d", c), {14'd0, busy, cmd_ready}, 16'b10);
      step();
    end
    @(negedge clk);
    check("b2b_c8", {14'd0, done, cmd_ready}, 16'b11);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_c9", {13'd0, outer, inner, busy}, 16'b011);
    step();
    wait_done("b2b_second_done");

    // Reset in the middle of a CAR_IN sequence.
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    @(negedge clk);
    check("rst_mid_accept", {15'd0, cmd_ready}, 16'd1);
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_c4", {14'd0, outer, inner}, 16'b11);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_c5", {11'd0, outer, inner, busy, cmd_ready, done}, 16'b00010);
    for (int c = 6; c <= 11; c++) begin
      step();
      @(negedge clk);
      check($sformatf("rst_mid_quiet_c%0d", c), {14'd0, busy, done}, 16'd0);
    end
`ifdef PARK_DRV_COUNT_EN
    check("rst_mid_counters", {cars_sent, peds_sent}, 16'd0);
`endif
    step();

    // HOLD_CYCLES=1, GAP_CYCLES=1 instance running CAR_OUT.
    cmd_valid1 = 1'b1;
    cmd1       = 2'b01;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("hold1_c%0d", c), {13'd0, outer1, inner1, done1}, {13'd0, exp1[c]});
      step();
      cmd_valid1 = 1'b0;
    end

`ifdef PARK_DRV_COUNT_EN
    repeat (3) run_cmd(2'b00);
    repeat (2) run_cmd(2'b10);
    step();
    check("cnt_cars_3", {8'd0, cars_sent}, 16'd3);
    check("cnt_peds_2", {8'd0, peds_sent}, 16'd2);
    repeat (260) run_cmd(2'b01);
    step();
    check("cnt_cars_sat", {8'd0, cars_sent}, 16'd255);
    check("cnt_peds_hold", {8'd0, peds_sent}, 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
